fetch_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register. Holds the PC, fetches from

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/fetch_buf.sv | 50 +++++
 rtl/fetch_stage.sv | 147 ++++++++++++++
 tb/tb_fetch_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: bubble instruction, reset PC, opcodes and the
// fetch FSM state type.
package riscv_pkg;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Major opcodes consumed by the main control decoder (InstrD[6:0])
   localparam logic [6:0] OP_LW   = 7'b000_0011;
   localparam logic [6:0] OP_SW   = 7'b010_0011;
   localparam logic [6:0] OP_R    = 7'b011_0011;
   localparam logic [6:0] OP_BEQ  = 7'b110_0011;
   localparam logic [6:0] OP_ADDI = 7'b001_0011;
   localparam logic [6:0] OP_JAL  = 7'b110_1111;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      HOLD
   } fetch_state_t;

   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_buf.sv
// One-entry holding buffer for a fetched instruction that arrived while decode
// was stalled. Clear wins over load.
module fetch_buf
   import riscv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        clear,
   input  logic [31:0] instr_in,
   input  logic [31:0] pc_in,
   output logic        valid,
   output logic [31:0] instr,
   output logic [31:0] pc
);

   logic        valid_q, valid_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_q, pc_d;

   always_comb begin
      valid_d = valid_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      if (clear) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = 1'b1;
         instr_d = instr_in;
         pc_d    = pc_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         instr_q <= NOP_INSTR;
         pc_q    <= 32'h0;
      end else begin
         valid_q <= valid_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
      end
   end

   assign valid = valid_q;
   assign instr = instr_q;
   assign pc    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register: one outstanding req/gnt/rvalid
// transaction, decode stall/flush handling and branch/jump redirects.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC_DEFAULT,
   parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        PCSrcE,
   input  logic [31:0] PCTargetE,
   input  logic        StallD,
   input  logic        FlushD,
   output logic [31:0] InstrD,
   output logic [31:0] PCD,
   output logic [31:0] PCPlus4D,
   output logic        ValidD
);

   import riscv_pkg::*;

   fetch_state_t state_q, state_d;
   logic [31:0]  pcf_q, pcf_d;
   logic [31:0]  req_pc_q, req_pc_d;
   logic         drop_q, drop_d;
   logic [31:0]  instr_q, instr_d;
   logic [31:0]  pcd_q, pcd_d;
   logic         valid_q, valid_d;

   logic         buf_load, buf_clear, buf_valid;
   logic [31:0]  buf_instr, buf_pc;
   logic [31:0]  target;
   logic         if_load;

   assign target  = align_pc(PCTargetE);
   assign if_load = ~StallD & ~FlushD;

   fetch_buf u_buf (
      .clk      (clk),
      .rst      (rst),
      .load     (buf_load),
      .clear    (buf_clear),
      .instr_in (imem_rdata),
      .pc_in    (req_pc_q),
      .valid    (buf_valid),
      .instr    (buf_instr),
      .pc       (buf_pc)
   );

   always_comb begin
      state_d   = state_q;
      pcf_d     = pcf_q;
      req_pc_d  = req_pc_q;
      drop_d    = drop_q;
      instr_d   = instr_q;
      pcd_d     = pcd_q;
      valid_d   = valid_q;
      buf_load  = 1'b0;
      buf_clear = 1'b0;
      imem_req  = 1'b0;

      // A load with nothing to deliver, or a flush, leaves a bubble; PCD holds.
      if (FlushD || if_load) begin
         valid_d = 1'b0;
         instr_d = NOP_INSTR;
      end

      case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            imem_req = 1'b1;
            if (imem_gnt) begin
               state_d  = WAIT;
               req_pc_d = pcf_q;
               pcf_d    = pcf_q + 32'd4;
               drop_d   = PCSrcE;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               state_d = REQ;
               drop_d  = 1'b0;
               if (!(drop_q || PCSrcE)) begin
                  if (if_load) begin
                     valid_d = 1'b1;
                     instr_d = imem_rdata;
                     pcd_d   = req_pc_q;
                  end else begin
                     buf_load = 1'b1;
                     state_d  = HOLD;
                  end
               end
            end else if (PCSrcE) begin
               drop_d = 1'b1;
            end
         end
         HOLD: begin
            if (PCSrcE || FlushD) begin
               buf_clear = 1'b1;
               state_d   = REQ;
            end else if (if_load) begin
               valid_d   = buf_valid;
               instr_d   = buf_instr;
               pcd_d     = buf_pc;
               buf_clear = 1'b1;
               state_d   = REQ;
            end
         end
         default: state_d = IDLE;
      endcase

      if (PCSrcE) begin
         pcf_d = target;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         pcf_q    <= RESET_PC;
         req_pc_q <= 32'h0;
         drop_q   <= 1'b0;
         instr_q  <= NOP_INSTR;
         pcd_q    <= 32'h0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pcf_q    <= pcf_d;
         req_pc_q <= req_pc_d;
         drop_q   <= drop_d;
         instr_q  <= instr_d;
         pcd_q    <= pcd_d;
         valid_q  <= valid_d;
      end
   end

   assign imem_addr = pcf_q;
   assign InstrD    = instr_q;
   assign PCD       = pcd_q;
   assign PCPlus4D  = pcd_q + 32'd4;
   assign ValidD    = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// memory timing, stalls, flushes, redirects and resets against a transaction model.
module tb_fetch_stage;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        imem_gnt = 1'b0, imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        PCSrcE = 1'b0, StallD = 1'b0, FlushD = 1'b0;
   logic [31:0] PCTargetE = 32'h0;
   logic        imem_req, ValidD;
   logic [31:0] imem_addr, InstrD, PCD, PCPlus4D;

   fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallD(StallD), .FlushD(FlushD),
      .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
   );

   // Second instance with a wrapping reset PC and a zero-wait memory
   logic        req2, valid2, rvalid2 = 1'b0;
   logic [31:0] addr2, instr2, pcd2, pcp42;
   logic [31:0] rec2 [2];
   int          n2 = 0;

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
      .clk(clk), .rst(rst), .imem_req(req2), .imem_addr(addr2),
      .imem_gnt(req2), .imem_rvalid(rvalid2), .imem_rdata(NOP_INSTR),
      .PCSrcE(1'b0), .PCTargetE(32'h0), .StallD(1'b0), .FlushD(1'b0),
      .InstrD(instr2), .PCD(pcd2), .PCPlus4D(pcp42), .ValidD(valid2)
   );

   always @(posedge clk) rvalid2 <= rst ? 1'b0 : req2;

   initial begin
      rec2[0] = 32'hDEAD_BEEF;
      rec2[1] = 32'hDEAD_BEEF;
   end

   always @(negedge clk) begin
      if (!rst && req2 && n2 < 2) begin
         rec2[n2] <= addr2;
         n2       <= n2 + 1;
      end
   end

   int n_vec = 0;
   int n_err = 0;

   // Transaction-level model of the fetch stage
   logic        check_en = 1'b0;
   logic        m_idle, m_out, m_out_stale, m_buf, m_valid;
   logic [31:0] m_pc, m_out_pc, m_buf_instr, m_buf_pc, m_instr, m_pcd;
   // Memory side: the request the memory currently owes a response to
   logic        pend = 1'b0;
   logic [31:0] pend_addr = 32'h0;
   logic        s_req = 1'b0;
   logic [31:0] s_addr = 32'h0;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h00A0_0033;
   endfunction

   function automatic logic exp_req();
      return !m_idle && !m_out && !m_buf;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic updateModel();
      logic        load, got, req_now;
      logic [31:0] g_instr, g_pc, nxt_pc;
      if (rst) begin
         m_idle = 1'b1; m_out = 1'b0; m_out_stale = 1'b0; m_buf = 1'b0;
         m_pc = 32'h0; m_out_pc = 32'h0; m_buf_instr = 32'h0; m_buf_pc = 32'h0;
         m_valid = 1'b0; m_instr = NOP_INSTR; m_pcd = 32'h0;
         pend = 1'b0;
      end else begin
         load    = !StallD && !FlushD;
         got     = 1'b0;
         g_instr = 32'h0;
         g_pc    = 32'h0;
         nxt_pc  = m_pc;
         req_now = exp_req();
         if (req_now && imem_gnt) begin
            m_out       = 1'b1;
            m_out_pc    = m_pc;
            m_out_stale = PCSrcE;
            nxt_pc      = m_pc + 32'd4;
         end else if (m_out) begin
            if (imem_rvalid) begin
               m_out = 1'b0;
               if (!m_out_stale && !PCSrcE) begin
                  if (load) begin
                     got = 1'b1; g_instr = imem_rdata; g_pc = m_out_pc;
                  end else begin
                     m_buf = 1'b1; m_buf_instr = imem_rdata; m_buf_pc = m_out_pc;
                  end
               end
            end else if (PCSrcE) begin
               m_out_stale = 1'b1;
            end
         end else if (m_buf) begin
            if (PCSrcE || FlushD) begin
               m_buf = 1'b0;
            end else if (load) begin
               got = 1'b1; g_instr = m_buf_instr; g_pc = m_buf_pc; m_buf = 1'b0;
            end
         end
         m_idle = 1'b0;
         if (PCSrcE) nxt_pc = PCTargetE & ~32'd3;
         m_pc = nxt_pc;
         if (got) begin
            m_valid = 1'b1; m_instr = g_instr; m_pcd = g_pc;
         end else if (FlushD || load) begin
            m_valid = 1'b0; m_instr = NOP_INSTR;
         end
         if (imem_rvalid) pend = 1'b0;
         if (s_req && imem_gnt) begin
            pend      = 1'b1;
            pend_addr = s_addr;
         end
      end
      check_en = 1'b1;
   endtask

   // One clock of stimulus: drive at negedge+1, update model at posedge,
   // return at the next negedge+1 with outputs settled.
   task automatic applyStimulus(input logic r, input logic g, input logic v, input logic pc,
                                input logic [31:0] tgt, input logic st, input logic fl);
      s_req       = imem_req;
      s_addr      = imem_addr;
      rst         = r;
      imem_gnt    = g;
      imem_rvalid = v;
      imem_rdata  = v ? (pend ? instr_of(pend_addr) : $urandom) : 32'h0;
      PCSrcE      = pc;
      PCTargetE   = tgt;
      StallD      = st;
      FlushD      = fl;
      @(posedge clk);
      updateModel();
      @(negedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         checkOutput("imem_req", 32'(imem_req), 32'(exp_req()));
         checkOutput("imem_addr", imem_addr, m_pc);
         checkOutput("ValidD", 32'(ValidD), 32'(m_valid));
         checkOutput("InstrD", InstrD, m_instr);
         checkOutput("PCD", PCD, m_pcd);
         checkOutput("PCPlus4D", PCPlus4D, m_pcd + 32'd4);
      end
   end

   initial begin
      @(negedge clk);
      #1;
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      checkOutput("rst ValidD", 32'(ValidD), 32'h0);
      checkOutput("rst InstrD", InstrD, 32'h0000_0013);
      checkOutput("rst PCD", PCD, 32'h0);
      checkOutput("rst PCPlus4D", PCPlus4D, 32'h4);
      checkOutput("rst req", 32'(imem_req), 32'h0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);

      $display("[TB] zero-wait streaming");
      for (int k = 0; k < 4; k++) begin
         checkOutput("t1 addr", imem_addr, 32'(k * 4));
         applyStimulus(0, 1, 0, 0, 0, 0, 0);
         applyStimulus(0, 0, 1, 0, 0, 0, 0);
         checkOutput("t1 ValidD", 32'(ValidD), 32'h1);
         checkOutput("t1 PCD", PCD, 32'(k * 4));
         checkOutput("t1 PCPlus4D", PCPlus4D, 32'(k * 4 + 4));
      end

      $display("[TB] stall while response arrives");
      applyStimulus(0, 1, 0, 0, 0, 1, 0);
      applyStimulus(0, 0, 1, 0, 0, 1, 0);
      checkOutput("t2 req in hold", 32'(imem_req), 32'h0);
      applyStimulus(0, 0, 0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 0);
      checkOutput("t2 held PCD", PCD, 32'd12);
      checkOutput("t2 held InstrD", InstrD, instr_of(32'd12));
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("t2 released PCD", PCD, 32'd16);
      checkOutput("t2 released InstrD", InstrD, instr_of(32'd16));

      $display("[TB] redirect while waiting");
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 32'h0000_0103, 0, 0);
      checkOutput("t3 redirect addr", imem_addr, 32'h0000_0100);
      applyStimulus(0, 0, 1, 0, 0, 0, 0);
      checkOutput("t3 dropped ValidD", 32'(ValidD), 32'h0);
      checkOutput("t3 refetch addr", imem_addr, 32'h0000_0100);
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 0, 0, 0);
      checkOutput("t3 target PCD", PCD, 32'h0000_0100);

      $display("[TB] flush with stall");
      applyStimulus(0, 0, 0, 0, 0, 1, 1);
      checkOutput("t4 ValidD", 32'(ValidD), 32'h0);
      checkOutput("t4 InstrD", InstrD, 32'h0000_0013);

      $display("[TB] reset mid-transaction");
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      checkOutput("t6 req", 32'(imem_req), 32'h0);
      checkOutput("t6 PCD", PCD, 32'h0);
      checkOutput("t6 InstrD", InstrD, 32'h0000_0013);
      applyStimulus(0, 0, 1, 0, 0, 0, 0);
      checkOutput("t6 first req", 32'(imem_req), 32'h1);
      checkOutput("t6 first addr", imem_addr, 32'h0);
      checkOutput("t6 ValidD", 32'(ValidD), 32'h0);

      $display("[TB] random traffic");
      for (int i = 0; i < 3000; i++) begin
         applyStimulus($urandom_range(149) == 0,
                       imem_req && ($urandom_range(3) != 0),
                       pend && ($urandom_range(2) != 0),
                       $urandom_range(9) == 0,
                       $urandom,
                       $urandom_range(2) == 0,
                       $urandom_range(9) == 0);
      end

      checkOutput("t5 first addr", rec2[0], 32'hFFFF_FFFC);
      checkOutput("t5 second addr", rec2[1], 32'h0000_0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
